// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: datapath width,
// fetch step and the controller state encoding.
package fetch_ctrl_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_HOLD     = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// Program counter register: loads cmd_address_next every cycle, resets to
// RESET_VECTOR.
module pc
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            a_reset_n,
   input  logic [XLEN-1:0] cmd_address_next,
   output logic [XLEN-1:0] cmd_address_current
);

   // PC state register
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         cmd_address_current <= RESET_VECTOR;
      end else begin
         cmd_address_current <= cmd_address_next;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding imem read, one-entry
// instruction holding stage, redirect/trap steering with stale-response drop.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            a_reset_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
   output logic [XLEN-1:0] instr_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   output logic            misalign_err
);

   fetch_state_e    state_r, state_next_s;
   logic            drop_r, drop_next_s;
   logic [XLEN-1:0] fetch_pc_r, fetch_pc_next_s;
   logic [XLEN-1:0] instr_data_r, instr_data_next_s;
   logic [XLEN-1:0] instr_pc_r, instr_pc_next_s;
   logic [XLEN-1:0] pc_s, pc_next_s;
   logic            misalign_r, misalign_next_s;
   logic            req_valid_r, instr_valid_r;
   logic            steer_s;
   logic [XLEN-1:0] target_s;

   // Trap wins over a same-cycle redirect; neither is honoured in IDLE.
   assign target_s = trap_valid ? trap_vector : redirect_target;
   assign steer_s  = (trap_valid || redirect_valid) && (state_r != ST_IDLE);

   pc #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
      .clk                 (clk),
      .a_reset_n           (a_reset_n),
      .cmd_address_next    (pc_next_s),
      .cmd_address_current (pc_s)
   );

   // Next-state and datapath update selection
   always_comb begin
      state_next_s      = state_r;
      drop_next_s       = drop_r;
      fetch_pc_next_s   = fetch_pc_r;
      instr_data_next_s = instr_data_r;
      instr_pc_next_s   = instr_pc_r;
      pc_next_s         = pc_s;
      misalign_next_s   = 1'b0;

      if (steer_s) begin
         pc_next_s       = word_align(target_s);
         misalign_next_s = (target_s[1:0] != 2'b00);
      end else begin
         pc_next_s       = pc_s;
      end

      case (state_r)
         ST_IDLE: begin
            state_next_s = ST_REQ;
         end
         ST_REQ: begin
            if (steer_s) begin
               // An already-accepted request must have its response swallowed.
               if (imem_req_ready) begin
                  drop_next_s  = 1'b1;
                  state_next_s = ST_WAIT_RSP;
               end else begin
                  state_next_s = ST_REQ;
               end
            end else if (imem_req_ready) begin
               fetch_pc_next_s = pc_s;
               pc_next_s       = pc_s + INSTR_STEP;
               state_next_s    = ST_WAIT_RSP;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_WAIT_RSP: begin
            if (steer_s) begin
               if (imem_rsp_valid) begin
                  drop_next_s  = 1'b0;
                  state_next_s = ST_REQ;
               end else begin
                  drop_next_s  = 1'b1;
                  state_next_s = ST_WAIT_RSP;
               end
            end else if (imem_rsp_valid) begin
               if (drop_r) begin
                  drop_next_s  = 1'b0;
                  state_next_s = ST_REQ;
               end else begin
                  instr_data_next_s = imem_rsp_data;
                  instr_pc_next_s   = fetch_pc_r;
                  state_next_s      = ST_HOLD;
               end
            end else begin
               state_next_s = ST_WAIT_RSP;
            end
         end
         ST_HOLD: begin
            if (steer_s || instr_ready) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            drop_next_s  = 1'b0;
         end
      endcase
   end

   // Controller state and registered outputs
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         state_r       <= ST_IDLE;
         drop_r        <= 1'b0;
         fetch_pc_r    <= RESET_VECTOR;
         instr_data_r  <= 32'h0000_0000;
         instr_pc_r    <= 32'h0000_0000;
         misalign_r    <= 1'b0;
         req_valid_r   <= 1'b0;
         instr_valid_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         drop_r        <= drop_next_s;
         fetch_pc_r    <= fetch_pc_next_s;
         instr_data_r  <= instr_data_next_s;
         instr_pc_r    <= instr_pc_next_s;
         misalign_r    <= misalign_next_s;
         req_valid_r   <= (state_next_s == ST_REQ);
         instr_valid_r <= (state_next_s == ST_HOLD);
      end
   end

   assign imem_req_valid = req_valid_r;
   assign imem_req_addr  = pc_s;
   assign instr_valid    = instr_valid_r;
   assign instr_data     = instr_data_r;
   assign instr_pc       = instr_pc_r;
   assign misalign_err   = misalign_r;

endmodule
